uart_rx_deserializer: RTL and testbench

- UART receive path, the counterpart of the transmit serializer.
- Oversamples the RX_IN serial line, detects and qualifies the start bit, and majority-votes each bit at mid-bit.
- Reassembles DATA_WIDTH bits, LSB first; checks optional parity and the stop bit.
- Presents the parallel word with a one-cycle DATA_VALID strobe plus error strobes to the downstream register file/FIFO.

---
 rtl/uart_rx_deserializer.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes RX_IN, qualifies the start bit,
// majority-votes each bit at mid-bit, and reassembles an LSB-first word
// with optional parity and stop-bit checking.
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  Busy
);

    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [5:0]            edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic                  par_flag_q, par_flag_d;
    logic                  stp_flag_q, stp_flag_d;
    logic [5:0]            presc_q, presc_d;
    logic                  pen_q, pen_d;
    logic                  ptyp_q, ptyp_d;

    logic [5:0] half;
    logic       last_edge, samp_lo, samp_mid, vote_edge, vote, fire, fire_ok;

    assign half      = {1'b0, presc_q[5:1]};
    assign last_edge = (edge_q == presc_q - 6'd1);
    assign samp_lo   = (edge_q == half - 6'd1);
    assign samp_mid  = (edge_q == half);
    assign vote_edge = (edge_q == half + 6'd1);
    assign vote      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);

    // Two-flop synchronizer for the asynchronous serial line, idling high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State register and frame datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            pdata_q    <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
            presc_q    <= 6'd16;
            pen_q      <= 1'b0;
            ptyp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            pdata_q    <= pdata_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            par_flag_q <= par_flag_d;
            stp_flag_q <= stp_flag_d;
            presc_q    <= presc_d;
            pen_q      <= pen_d;
            ptyp_q     <= ptyp_d;
        end
    end

    // Next-state: edge/bit counting, mid-bit sampling and per-state bit handling
    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pdata_d    = pdata_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        par_flag_d = par_flag_q;
        stp_flag_d = stp_flag_q;
        presc_d    = presc_q;
        pen_d      = pen_q;
        ptyp_d     = ptyp_q;

        if (state_q == IDLE) begin
            // The cycle rx_s is first seen low is edge 0 of the start bit
            if (!rx_s_q) begin
                state_d    = START;
                edge_d     = 6'd1;
                bit_d      = '0;
                par_flag_d = 1'b0;
                stp_flag_d = 1'b0;
                presc_d    = PRESCALE;
                pen_d      = PAR_EN;
                ptyp_d     = PAR_TYP;
            end
        end else begin
            edge_d = last_edge ? 6'd0 : edge_q + 6'd1;
            if (samp_lo)  s0_d = rx_s_q;
            if (samp_mid) s1_d = rx_s_q;

            case (state_q)
                START: begin
                    if (vote_edge && vote) begin
                        state_d = IDLE;
                        edge_d  = '0;
                    end else if (last_edge) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (vote_edge) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                    if (last_edge) begin
                        if (bit_q == BW'(DATA_WIDTH - 1)) begin
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (vote_edge) par_flag_d = vote ^ (^shift_q) ^ ptyp_q;
                    if (last_edge) state_d = STOP;
                end
                STOP: begin
                    if (vote_edge) stp_flag_d = ~vote;
                    if (last_edge) begin
                        state_d = IDLE;
                        if (!par_flag_q && !stp_flag_q) pdata_d = shift_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: strobes fire in the last cycle of the stop bit
    always_comb begin
        fire       = (state_q == STOP) && last_edge;
        fire_ok    = fire && !par_flag_q && !stp_flag_q;
        DATA_VALID = fire_ok;
        PAR_ERR    = fire && par_flag_q;
        STP_ERR    = fire && stp_flag_q;
        P_DATA     = fire_ok ? shift_q : pdata_q;
        // Busy also covers the edge-0 cycle, when IDLE is committing to START
        Busy       = (state_q != IDLE) || !rx_s_q;
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames with a
// scoreboard of expected strobes checked by a negedge monitor.
module tb_uart_rx_deserializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       Busy;

    uart_rx_deserializer #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] kind;   // {PAR_ERR, STP_ERR, DATA_VALID}
        logic [7:0] data;
        int         cyc;
        int         tol;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         busy_run = 0;
    int         last_busy = 0;
    logic [7:0] model_pdata = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: Busy run length and scoreboard comparison on every strobe
    always @(negedge CLK) begin
        exp_t e;
        int   obs_cyc;
        if (Busy) begin
            busy_run++;
        end else begin
            if (busy_run != 0) last_busy = busy_run;
            busy_run = 0;
        end
        if (DATA_VALID || PAR_ERR || STP_ERR) begin
            check("sb_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("strobe_kind", {29'd0, PAR_ERR, STP_ERR, DATA_VALID}, {29'd0, e.kind});
                check("p_data", {24'd0, P_DATA}, {24'd0, e.data});
                obs_cyc = ((cyc - e.cyc) <= e.tol && (e.cyc - cyc) <= e.tol) ? e.cyc : cyc;
                check("strobe_cycle", obs_cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit pbit, input bit stopb, input int spike_bit,
                              input int new_presc, input int tol);
        exp_t e;
        bit   perr, serr;
        int   nb;
        PRESCALE = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        nb   = 10 + (pen ? 1 : 0);
        perr = pen && (pbit != ((^d) ^ ptyp));
        serr = !stopb;
        e.cyc = cyc + nb * p + 1;
        e.tol = tol;
        if (!perr && !serr) begin
            e.kind = 3'b001;
            model_pdata = d;
            e.data = d;
        end else begin
            e.kind = {perr, serr, 1'b0};
            e.data = model_pdata;
        end
        exp_q.push_back(e);
        for (int b = 0; b < nb; b++) begin
            logic v;
            if (b == 0) v = 1'b0;
            else if (b <= 8) v = d[b-1];
            else if (pen && b == 9) v = pbit;
            else v = stopb;
            for (int j = 0; j < p; j++) begin
                RX_IN = (b == spike_bit && j == p / 2) ? ~v : v;
                @(posedge CLK); #1;
            end
            if (b == 0 && new_presc != 0) PRESCALE = 6'(new_presc);
        end
    endtask

    initial begin
        int         start;
        logic [7:0] rd;
        RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #2;
        check("rst_p_data", {24'd0, P_DATA}, 0);
        check("rst_valid", {31'd0, DATA_VALID}, 0);
        check("rst_par_err", {31'd0, PAR_ERR}, 0);
        check("rst_stp_err", {31'd0, STP_ERR}, 0);
        check("rst_busy", {31'd0, Busy}, 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        idle(5);

        // 0xA5, 16x, no parity
        last_busy = 0;
        send_frame(8'hA5, 16, 0, 0, 0, 1, -1, 0, 0);
        idle(10);
        check("busy_len_a5", last_busy, 160);

        // 0x3C, 8x, even parity: good then bad parity bit
        send_frame(8'h3C, 8, 1, 0, 0, 1, -1, 0, 0);
        idle(6);
        send_frame(8'h3C, 8, 1, 0, 1, 1, -1, 0, 0);
        idle(6);
        check("p_data_after_par_err", {24'd0, P_DATA}, 32'h3C);

        // 0x55, 32x, stop bit low
        send_frame(8'h55, 32, 0, 0, 0, 0, -1, 0, 0);
        idle(6);
        check("p_data_after_stp_err", {24'd0, P_DATA}, 32'h3C);

        // Odd parity wrong and stop low: both error strobes together
        send_frame(8'h0F, 8, 1, 1, 0, 0, -1, 0, 0);
        idle(6);

        // Start glitch: 3 low cycles at 16x
        PRESCALE = 6'd16; PAR_EN = 1'b0;
        start = cyc;
        RX_IN = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        RX_IN = 1'b1;
        while (cyc < start + 11) begin @(posedge CLK); #1; end
        check("glitch_busy_at_edge9", {31'd0, Busy}, 1);
        @(posedge CLK); #1;
        check("glitch_busy_after_edge9", {31'd0, Busy}, 0);
        idle(10);
        send_frame(8'h81, 16, 0, 0, 0, 1, -1, 0, 0);
        idle(4);

        // Back-to-back 0x01, 0xFE with a 1-cycle spike at mid-bit of data bit 3
        send_frame(8'h01, 16, 0, 0, 0, 1, -1, 0, 0);
        send_frame(8'hFE, 16, 0, 0, 0, 1, 4, 0, 1);
        idle(6);
        check("p_data_after_b2b", {24'd0, P_DATA}, 32'hFE);

        // Reset asserted during data bit 4
        rd = 8'h5A;
        PRESCALE = 6'd16;
        for (int b = 0; b < 5; b++) begin
            RX_IN = (b == 0) ? 1'b0 : rd[b-1];
            for (int j = 0; j < ((b == 4) ? 8 : 16); j++) begin @(posedge CLK); #1; end
        end
        RX_IN = rd[4];
        #2 RST = 1'b1;
        #1;
        check("midrst_p_data", {24'd0, P_DATA}, 0);
        check("midrst_valid", {31'd0, DATA_VALID}, 0);
        check("midrst_par_err", {31'd0, PAR_ERR}, 0);
        check("midrst_stp_err", {31'd0, STP_ERR}, 0);
        check("midrst_busy", {31'd0, Busy}, 0);
        RX_IN = 1'b1;
        model_pdata = 8'h00;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        idle(10);

        // 0x7E at 16x with PRESCALE switched to 8 after the start bit
        send_frame(8'h7E, 16, 0, 0, 0, 1, -1, 8, 0);
        idle(10);
        check("p_data_final", {24'd0, P_DATA}, 32'h7E);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge CLK);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
